// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the M-stage data memory access controller:
// data width and the controller state encoding.
package mem_access_ctrl_pkg;

  localparam int D_WIDTH = 32;

  typedef enum logic [1:0] {
    MEMC_IDLE = 2'd0,
    MEMC_REQ  = 2'd1,
    MEMC_WAIT = 2'd2,
    MEMC_DONE = 2'd3
  } memc_state_e;

  function automatic logic is_mem_op(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Cycle counter that flags the last permitted REQ+WAIT cycle of an access.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Raised during the final allowed cycle so the FSM aborts on that edge.
  assign expire = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage load/store sequencer for a req/gnt/rvalid data memory; freezes F..M while busy.
// Optional abort of a stuck access is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int A_WIDTH        = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_MemReadM,
  input  logic               i_MemWriteM,
  input  logic [A_WIDTH-1:0] i_AddrM,
  input  logic [D_WIDTH-1:0] i_WDataM,
  output logic               o_StallM,
  output logic [D_WIDTH-1:0] o_RD,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [A_WIDTH-1:0] o_mem_addr,
  output logic [D_WIDTH-1:0] o_mem_wdata,
  input  logic               i_mem_gnt,
  input  logic               i_mem_rvalid,
  input  logic [D_WIDTH-1:0] i_mem_rdata,
  output logic               o_mem_err
);

  memc_state_e state;
  logic        start;
  logic        timeout_hit;
  logic        mem_err_q;

  assign start     = is_mem_op(i_MemReadM, i_MemWriteM);
  assign o_StallM  = ((state == MEMC_IDLE) && start) ||
                     (state == MEMC_REQ) || (state == MEMC_WAIT);
  assign o_mem_err = mem_err_q;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state == MEMC_IDLE) && start),
    .enable ((state == MEMC_REQ) || (state == MEMC_WAIT)),
    .expire (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // A store with MemRead also high is treated as a store; completion always wins over timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MEMC_IDLE;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_RD        <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      mem_err_q <= 1'b0;
      case (state)
        MEMC_IDLE: begin
          if (start) begin
            o_mem_we    <= i_MemWriteM;
            o_mem_addr  <= i_AddrM;
            o_mem_wdata <= i_WDataM;
            o_mem_req   <= 1'b1;
            state       <= MEMC_REQ;
          end
        end
        MEMC_REQ: begin
          if (i_mem_gnt) begin
            o_mem_req <= 1'b0;
            if (o_mem_we) begin
              state <= MEMC_DONE;
            end else if (i_mem_rvalid) begin
              o_RD  <= i_mem_rdata;
              state <= MEMC_DONE;
            end else begin
              state <= MEMC_WAIT;
            end
          end else if (timeout_hit) begin
            o_mem_req <= 1'b0;
            o_RD      <= '0;
            mem_err_q <= 1'b1;
            state     <= MEMC_DONE;
          end
        end
        MEMC_WAIT: begin
          if (i_mem_rvalid) begin
            o_RD  <= i_mem_rdata;
            state <= MEMC_DONE;
          end else if (timeout_hit) begin
            o_RD      <= '0;
            mem_err_q <= 1'b1;
            state     <= MEMC_DONE;
          end
        end
        MEMC_DONE: state <= MEMC_IDLE;
        default:   state <= MEMC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset/timeout sequences,
// and randomized accesses against a simple latency/data model. Honours MEM_TIMEOUT_EN.
module tb_mem_access_ctrl;

  localparam int AW = 32;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read_m = 1'b0;
  logic        mem_write_m = 1'b0;
  logic [31:0] addr_m = '0;
  logic [31:0] wdata_m = '0;
  logic        stall_m;
  logic [31:0] rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err;

  int          assert_count = 0;
  int          fail_count = 0;
  logic [31:0] model_rd = '0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gnt_delay;
    int          rvalid_delay;
    logic [31:0] rdata;
    int          exp_stall;
    logic [31:0] exp_rd;
    logic        exp_we;
  } vec_t;

  vec_t tbl [6];

  mem_access_ctrl #(
    .A_WIDTH        (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_MemReadM   (mem_read_m),
    .i_MemWriteM  (mem_write_m),
    .i_AddrM      (addr_m),
    .i_WDataM     (wdata_m),
    .o_StallM     (stall_m),
    .o_RD         (rd),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata),
    .o_mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Plays the M stage and the memory for one access, counting stall and request cycles.
  task automatic applyStimulus(input vec_t v, input string tag);
    int   stall_cycles = 0;
    int   req_cycles = 0;
    int   wait_cycles = 0;
    int   field_errs = 0;
    int   cyc = 0;
    bit   granted = 0;
    bit   done = 0;
    logic [31:0] rd_at_done = '0;
    mem_read_m  = v.rd;
    mem_write_m = v.wr;
    addr_m      = v.addr;
    wdata_m     = v.wdata;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    settle();
    checkOutput({tag, " idle_req"}, 32'(mem_req), 32'd0);
    checkOutput({tag, " idle_stall"}, 32'(stall_m), 32'd1);
    next_cycle();
    while (!done && cyc < 64) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom();
      if (mem_req) begin
        if (mem_addr !== v.addr || mem_we !== v.exp_we || mem_wdata !== v.wdata) field_errs++;
        if (req_cycles == v.gnt_delay) begin
          mem_gnt = 1'b1;
          granted = 1'b1;
          if (!v.exp_we && v.rvalid_delay == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
          end
        end
        req_cycles++;
      end else if (granted && !v.exp_we) begin
        wait_cycles++;
        if (wait_cycles == v.rvalid_delay) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.rdata;
        end
      end
      settle();
      if (stall_m) begin
        stall_cycles++;
      end else begin
        done       = 1'b1;
        rd_at_done = rd;
        checkOutput({tag, " done_req"}, 32'(mem_req), 32'd0);
        checkOutput({tag, " done_err"}, 32'(mem_err), 32'd0);
      end
      next_cycle();
      cyc++;
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    checkOutput({tag, " completed"}, 32'(done), 32'd1);
    checkOutput({tag, " stall_cycles"}, 32'(1 + stall_cycles), 32'(v.exp_stall));
    checkOutput({tag, " req_cycles"}, 32'(req_cycles), 32'(v.gnt_delay + 1));
    checkOutput({tag, " req_fields"}, 32'(field_errs), 32'd0);
    checkOutput({tag, " rd"}, rd_at_done, v.exp_rd);
  endtask

  // Non-memory instructions in M, with stray memory responses that must be ignored.
  task automatic applyIdle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      mem_read_m  = 1'b0;
      mem_write_m = 1'b0;
      addr_m      = $urandom();
      wdata_m     = $urandom();
      mem_gnt     = 1'($urandom_range(0, 1));
      mem_rvalid  = 1'($urandom_range(0, 1));
      mem_rdata   = $urandom();
      settle();
      checkOutput({tag, " stall"}, 32'(stall_m), 32'd0);
      checkOutput({tag, " req"}, 32'(mem_req), 32'd0);
      checkOutput({tag, " rd"}, rd, model_rd);
      next_cycle();
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  function automatic vec_t make_random(input int op);
    vec_t v;
    v.rd           = (op == 1) || (op == 3);
    v.wr           = (op == 2) || (op == 3);
    v.addr         = $urandom() & 32'hFFFF_FFFC;
    v.wdata        = $urandom();
    v.gnt_delay    = $urandom_range(0, 3);
    v.rvalid_delay = $urandom_range(0, 3);
    v.rdata        = $urandom();
    v.exp_we       = v.wr;
    v.exp_stall    = 2 + v.gnt_delay + (v.wr ? 0 : v.rvalid_delay);
    v.exp_rd       = v.wr ? model_rd : v.rdata;
    return v;
  endfunction

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h100, 32'h0,    0, 0, 32'hDEADBEEF, 2, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h200, 32'h1234, 3, 0, 32'h0,        5, 32'hDEADBEEF, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 32'h104, 32'h0,    0, 4, 32'hA5A5A5A5, 6, 32'hA5A5A5A5, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 32'h300, 32'h55AA, 1, 0, 32'hFFFFFFFF, 3, 32'hA5A5A5A5, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 32'h304, 32'h0,    2, 1, 32'h0BADF00D, 5, 32'h0BADF00D, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'h308, 32'h77,   0, 0, 32'h0,        2, 32'h0BADF00D, 1'b1};

    #1;
    checkOutput("por stall", 32'(stall_m), 32'd0);
    checkOutput("por req", 32'(mem_req), 32'd0);
    checkOutput("por rd", rd, 32'd0);
    checkOutput("por err", 32'(mem_err), 32'd0);
    checkOutput("por addr", mem_addr, 32'd0);
    checkOutput("por we", 32'(mem_we), 32'd0);
    checkOutput("por wdata", mem_wdata, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_cycle();
    applyIdle(2, "idle0");

    // Back-to-back directed vectors: each access starts the cycle after the previous DONE.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i], $sformatf("vec%0d", i));
    end
    model_rd = 32'h0BADF00D;
    applyIdle(1, "idle1");

    // Reset while a load to 0x40 sits in WAIT.
    mem_read_m = 1'b1;
    addr_m     = 32'h40;
    next_cycle();
    settle();
    checkOutput("rst req_up", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    next_cycle();
    settle();
    checkOutput("rst in_wait_stall", 32'(stall_m), 32'd1);
    rst_n      = 1'b0;
    mem_read_m = 1'b0;
    #1;
    checkOutput("rst req", 32'(mem_req), 32'd0);
    checkOutput("rst stall", 32'(stall_m), 32'd0);
    checkOutput("rst rd", rd, 32'd0);
    checkOutput("rst addr", mem_addr, 32'd0);
    checkOutput("rst we", 32'(mem_we), 32'd0);
    next_cycle();
    rst_n    = 1'b1;
    model_rd = '0;
    next_cycle();
    applyIdle(2, "post_rst");
    applyStimulus('{1'b1, 1'b0, 32'h44, 32'h0, 0, 0, 32'h600DF00D, 2, 32'h600DF00D, 1'b0}, "post_rst_load");
    model_rd = 32'h600DF00D;

    // Randomized traffic checked against the latency/data model.
    for (int i = 0; i < 40; i++) begin
      int   op;
      vec_t v;
      op = $urandom_range(0, 3);
      if (op == 0) begin
        applyIdle($urandom_range(1, 2), $sformatf("rnd%0d idle", i));
      end else begin
        v = make_random(op);
        applyStimulus(v, $sformatf("rnd%0d", i));
        model_rd = v.exp_rd;
      end
    end

    applyStimulus('{1'b1, 1'b0, 32'h500, 32'h0, 0, 0, 32'hCAFEF00D, 2, 32'hCAFEF00D, 1'b0}, "pre_to_load");
    model_rd = 32'hCAFEF00D;

`ifdef MEM_TIMEOUT_EN
    begin
      int req_cycles = 0;
      bit found = 0;
      mem_read_m = 1'b1;
      addr_m     = 32'h504;
      next_cycle();
      for (int c = 0; c < 40 && !found; c++) begin
        settle();
        if (mem_err) begin
          found = 1'b1;
          checkOutput("to rd", rd, 32'd0);
          checkOutput("to stall", 32'(stall_m), 32'd0);
          checkOutput("to req", 32'(mem_req), 32'd0);
        end else if (mem_req) begin
          req_cycles++;
        end
        next_cycle();
      end
      checkOutput("to err_seen", 32'(found), 32'd1);
      checkOutput("to req_cycles", 32'(req_cycles), 32'(TO));
      mem_read_m = 1'b0;
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h12345678;
      settle();
      checkOutput("to err_pulse", 32'(mem_err), 32'd0);
      checkOutput("to late_stall", 32'(stall_m), 32'd0);
      next_cycle();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      model_rd   = '0;
      applyIdle(2, "to_after");
    end
`else
    mem_read_m = 1'b1;
    addr_m     = 32'h504;
    for (int c = 0; c < 100; c++) begin
      next_cycle();
    end
    settle();
    checkOutput("hang stall", 32'(stall_m), 32'd1);
    checkOutput("hang req", 32'(mem_req), 32'd1);
    checkOutput("hang err", 32'(mem_err), 32'd0);
    checkOutput("hang rd", rd, model_rd);
    rst_n      = 1'b0;
    mem_read_m = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences M-stage loads and stores against a variable-latency data memory with a req/gnt/rvalid handshake.
- Freezes the upstream pipeline (F..M) while an access is outstanding.
- Presents load data to the MEM/WB pipeline register on the completion cycle.
- Sits between the M stage, the data memory port and the MEM/WB register.

Parameters:
- D_WIDTH, 32 (taken from shared param include), data width.
- A_WIDTH, 32, address width.
- TIMEOUT_CYCLES, 255, maximum REQ+WAIT cycles before abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_MemReadM  in  1  M-stage load
- i_MemWriteM  in  1  M-stage store
- i_AddrM  in  A_WIDTH  M-stage ALU result (address)
- i_WDataM  in  D_WIDTH  store data
- o_StallM  out  1  freeze F/D/E/M stage registers
- o_RD  out  D_WIDTH  load data to MEM/WB i_RD
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1 = write
- o_mem_addr  out  A_WIDTH  request address
- o_mem_wdata  out  D_WIDTH  request write data
- i_mem_gnt  in  1  request accepted
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  D_WIDTH  read data
- o_mem_err  out  1  timeout pulse (tied 0 without feature)

Behaviour:
- Reset (async, rst_n low): all of the following, at any time including mid-access, with no memory transaction completed or retried.
  - state=IDLE
  - o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0
  - o_RD=0, o_mem_err=0, timeout counter=0
- States: IDLE, REQ, WAIT, DONE. Encoding 2 bits.
- IDLE:
  - If i_MemWriteM|i_MemReadM: latch addr/wdata/we into request registers, go to REQ.
  - If both are high, write wins (we=1).
  - Otherwise stay.
- REQ: o_mem_req=1 with latched addr/we/wdata held stable until gnt.
  - gnt & we → DONE.
  - gnt & !we & rvalid (same cycle) → capture rdata into o_RD, go to DONE.
  - gnt & !we & !rvalid → WAIT.
  - !gnt → stay.
  - o_mem_req drops the cycle after gnt.
- WAIT: on rvalid, capture rdata into o_RD and go to DONE; else stay. rvalid outside WAIT/REQ-with-gnt is ignored.
- DONE: one cycle, then → IDLE unconditionally. The M instruction advances into MEM/WB at this edge.
- o_StallM (combinational) = (IDLE & (MemRead|MemWrite)) | REQ | WAIT. Deasserted in DONE.
- Latency: zero-wait memory (gnt in first REQ cycle, rvalid with gnt) gives 2 stall cycles per access, DONE on the 3rd cycle. Each extra gnt/rvalid wait cycle adds 1.
- o_RD:
  - Registered.
  - Holds the last captured load value.
  - Unchanged by stores.
  - Valid in DONE and thereafter until the next capture.
- Non-memory instructions in M: no stall, no request, o_RD unchanged.
- Back-to-back accesses: the instruction entering M after DONE is detected in IDLE the following cycle. There is no re-trigger of the completed instruction.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - Counter clears on IDLE→REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES without completion: go to DONE, drop o_mem_req, load o_RD=0, pulse o_mem_err=1 for exactly the DONE cycle.
  - Late gnt/rvalid from the aborted access is ignored.
- Undefined: no counter; REQ/WAIT wait indefinitely; o_mem_err constant 0.

Decomposition:
- D_WIDTH and the state encodings (MEMC_IDLE=0, MEMC_REQ=1, MEMC_WAIT=2, MEMC_DONE=3) go in the shared param include.
- One sub-module, mem_timeout_cnt: clear, enable, expire output, parameter TIMEOUT_CYCLES. It is instantiated only under MEM_TIMEOUT_EN.

Test Plan:
1. Reset mid-WAIT (load to 0x40 outstanding), assert rst_n=0 → same cycle o_mem_req=0, o_StallM=0 with MemRead low, o_RD=0. After release, state=IDLE.
2. Load 0x100, memory gnt cycle 1 and rvalid with rdata=0xDEADBEEF same cycle → o_StallM high 2 cycles, DONE cycle 3, o_RD=0xDEADBEEF.
3. Store addr 0x200 data 0x1234, gnt withheld 3 cycles → o_mem_req/we/addr/wdata stable 4 cycles, stall 5 cycles, o_RD unchanged, DONE then IDLE.
4. Load with gnt at cycle 1 and rvalid 4 cycles later (rdata=0xA5A5A5A5) → WAIT held 4 cycles, o_RD=0xA5A5A5A5 in DONE.
5. MemRead and MemWrite both high → o_mem_we=1, store completes, o_RD unchanged. Follow with back-to-back load → second access starts the cycle after DONE, no duplicate request.
6. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never grants → o_mem_err=1 for one cycle after 8 REQ cycles, o_RD=0, o_StallM drops. Without the macro the controller still stalls at cycle 100.
